multicycle_control: RTL and testbench

//  Main control FSM for the 32-bit multicycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback
//  per opcode, drives all datapath enables and the 2-bit ALU op consumed by AluControl (op[1]->AluOp1,
//  op[0]->AluOp0). Stalls on a memory ready handshake. Sits beside AluControl inside the CPU top.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/multicycle_control.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode, ALU-op, mux-select and FSM state encodings
//               for the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // AluControl encoding: bit 1 -> AluOp1, bit 0 -> AluOp0
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ORI_EX    = 4'd11,
    S_I_WB      = 4'd12
  } state_e;

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle MIPS datapath; sequences
//               each instruction and drives all datapath enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import mips_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic [1:0]         alu_op,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               w_ready;

  assign w_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state   = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= STATE_W'(S_FETCH);
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = STATE_W'(S_FETCH);
    alu_op        = ALUOP_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;

    case (r_state)
      STATE_W'(S_FETCH): begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = w_ready;
        pc_write  = w_ready;
        w_next    = w_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
      end
      STATE_W'(S_DECODE): begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: w_next = STATE_W'(S_MEM_ADDR);
          OP_RTYPE:     w_next = STATE_W'(S_R_EXEC);
          OP_BEQ:       w_next = STATE_W'(S_BRANCH);
          OP_J:         w_next = STATE_W'(S_JUMP);
          OP_ADDI:      w_next = STATE_W'(S_ADDI_EX);
          OP_ORI:       w_next = STATE_W'(S_ORI_EX);
          default:      illegal_op = 1'b1;
        endcase
      end
      STATE_W'(S_MEM_ADDR): begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_SW) ? STATE_W'(S_MEM_WRITE) : STATE_W'(S_MEM_READ);
      end
      STATE_W'(S_MEM_READ): begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = w_ready ? STATE_W'(S_MEM_WB) : STATE_W'(S_MEM_READ);
      end
      STATE_W'(S_MEM_WB): begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      STATE_W'(S_MEM_WRITE): begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = w_ready;
        w_next     = w_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEM_WRITE);
      end
      STATE_W'(S_R_EXEC): begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        w_next    = STATE_W'(S_R_WB);
      end
      STATE_W'(S_R_WB): begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      STATE_W'(S_BRANCH): begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      STATE_W'(S_JUMP): begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      STATE_W'(S_ADDI_EX), STATE_W'(S_ORI_EX): begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (r_state == STATE_W'(S_ORI_EX)) ? ALUOP_OR : ALUOP_ADD;
        w_next    = STATE_W'(S_I_WB);
      end
      STATE_W'(S_I_WB): begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    // Holding reset silences the datapath so an aborted instruction leaves no side effects
    if (!rst_n) begin
      alu_op        = ALUOP_ADD;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;
  import mips_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  int nChecks = 0;
  int nFails  = 0;

  multicycle_control #(.USE_MEM_READY(1), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .illegal_op(illegal_op), .instr_done(instr_done), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[2], pc_source[2], alu_op[2], illegal_op, instr_done}
  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, instr_done};

  localparam logic [17:0] E_ZERO     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_FETCH_RD = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_FETCH_WT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] E_ILLEGAL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] E_ADDR     = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_MRD      = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MWB      = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
  localparam logic [17:0] E_MWR_WT   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MWR_RD   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
  localparam logic [17:0] E_REXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [17:0] E_RWB      = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
  localparam logic [17:0] E_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [17:0] E_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_0_1;
  localparam logic [17:0] E_ORI      = 18'b0_0_0_0_0_0_0_0_0_1_10_00_11_0_0;
  localparam logic [17:0] E_IWB      = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
  } step_t;

  function automatic step_t mk(logic [5:0] op, logic rdy, state_e st, logic [17:0] out);
    mk = {op, rdy, 4'(st), out};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    repeat (2) @(negedge clk);
    #1;
    nChecks++;
    if (state !== 4'(S_FETCH) || outs !== E_ZERO) begin
      nFails++;
      $display("FAIL reset_init: got state=%0d outs=%b, want state=%0d outs=%b", state, outs, S_FETCH, E_ZERO);
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    nChecks++;
    if (state !== 4'(S_FETCH) || outs !== E_FETCH_WT) begin
      nFails++;
      $display("FAIL reset_fetch_wait: got state=%0d outs=%b, want state=%0d outs=%b", state, outs, S_FETCH, E_FETCH_WT);
    end
    // reset reasserted mid-FETCH with memory ready: nothing may leak out
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst_n = 1'b0; mem_ready = 1'b1; #1;
      nChecks++;
      if (state !== 4'(S_FETCH) || outs !== E_ZERO) begin
        nFails++;
        $display("FAIL reset_hold[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, S_FETCH, E_ZERO);
      end
    end
    @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0;
  endtask

  task automatic test_lw();
    step_t seq[$];
    seq = {mk(6'h3F, 1'b1, S_FETCH,    E_FETCH_RD),
           mk(OP_LW, 1'b1, S_DECODE,   E_DECODE),
           mk(OP_LW, 1'b1, S_MEM_ADDR, E_ADDR),
           mk(OP_LW, 1'b1, S_MEM_READ, E_MRD),
           mk(OP_LW, 1'b1, S_MEM_WB,   E_MWB)};
    foreach (seq[i]) begin
      @(negedge clk); opcode = seq[i].op; mem_ready = seq[i].rdy; #1;
      nChecks++;
      if (state !== seq[i].st || outs !== seq[i].out) begin
        nFails++;
        $display("FAIL lw[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, seq[i].st, seq[i].out);
      end
    end
  endtask

  task automatic test_sw_stall();
    step_t seq[$];
    seq = {mk(OP_SW, 1'b1, S_FETCH,     E_FETCH_RD),
           mk(OP_SW, 1'b1, S_DECODE,    E_DECODE),
           mk(OP_SW, 1'b1, S_MEM_ADDR,  E_ADDR),
           mk(OP_LW, 1'b0, S_MEM_WRITE, E_MWR_WT),
           mk(6'h00, 1'b0, S_MEM_WRITE, E_MWR_WT),
           mk(6'h3F, 1'b0, S_MEM_WRITE, E_MWR_WT),
           mk(OP_LW, 1'b1, S_MEM_WRITE, E_MWR_RD)};
    foreach (seq[i]) begin
      @(negedge clk); opcode = seq[i].op; mem_ready = seq[i].rdy; #1;
      nChecks++;
      if (state !== seq[i].st || outs !== seq[i].out) begin
        nFails++;
        $display("FAIL sw_stall[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, seq[i].st, seq[i].out);
      end
    end
  endtask

  task automatic test_alu_ops();
    step_t seq[$];
    seq = {mk(OP_RTYPE, 1'b1, S_FETCH,   E_FETCH_RD),
           mk(OP_RTYPE, 1'b1, S_DECODE,  E_DECODE),
           mk(OP_RTYPE, 1'b1, S_R_EXEC,  E_REXEC),
           mk(OP_RTYPE, 1'b1, S_R_WB,    E_RWB),
           mk(OP_ORI,   1'b1, S_FETCH,   E_FETCH_RD),
           mk(OP_ORI,   1'b1, S_DECODE,  E_DECODE),
           mk(OP_ORI,   1'b1, S_ORI_EX,  E_ORI),
           mk(OP_ORI,   1'b1, S_I_WB,    E_IWB),
           mk(OP_ADDI,  1'b1, S_FETCH,   E_FETCH_RD),
           mk(OP_ADDI,  1'b1, S_DECODE,  E_DECODE),
           mk(OP_ADDI,  1'b1, S_ADDI_EX, E_ADDR),
           mk(OP_ADDI,  1'b1, S_I_WB,    E_IWB)};
    foreach (seq[i]) begin
      @(negedge clk); opcode = seq[i].op; mem_ready = seq[i].rdy; #1;
      nChecks++;
      if (state !== seq[i].st || outs !== seq[i].out) begin
        nFails++;
        $display("FAIL alu_ops[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, seq[i].st, seq[i].out);
      end
    end
  endtask

  task automatic test_branch_jump();
    step_t seq[$];
    seq = {mk(OP_BEQ, 1'b1, S_FETCH,  E_FETCH_RD),
           mk(OP_BEQ, 1'b1, S_DECODE, E_DECODE),
           mk(OP_BEQ, 1'b1, S_BRANCH, E_BRANCH),
           mk(OP_J,   1'b1, S_FETCH,  E_FETCH_RD),
           mk(OP_J,   1'b1, S_DECODE, E_DECODE),
           mk(OP_J,   1'b1, S_JUMP,   E_JUMP)};
    foreach (seq[i]) begin
      @(negedge clk); opcode = seq[i].op; mem_ready = seq[i].rdy; #1;
      nChecks++;
      if (state !== seq[i].st || outs !== seq[i].out) begin
        nFails++;
        $display("FAIL branch_jump[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, seq[i].st, seq[i].out);
      end
    end
  endtask

  task automatic test_illegal();
    step_t seq[$];
    seq = {mk(6'h3F, 1'b1, S_FETCH,  E_FETCH_RD),
           mk(6'h3F, 1'b1, S_DECODE, E_ILLEGAL),
           mk(6'h3F, 1'b0, S_FETCH,  E_FETCH_WT),
           mk(6'h3F, 1'b0, S_FETCH,  E_FETCH_WT)};
    foreach (seq[i]) begin
      @(negedge clk); opcode = seq[i].op; mem_ready = seq[i].rdy; #1;
      nChecks++;
      if (state !== seq[i].st || outs !== seq[i].out) begin
        nFails++;
        $display("FAIL illegal[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, seq[i].st, seq[i].out);
      end
    end
  endtask

  task automatic test_reset_abort();
    step_t seq[$];
    seq = {mk(OP_LW, 1'b1, S_FETCH,    E_FETCH_RD),
           mk(OP_LW, 1'b1, S_DECODE,   E_DECODE),
           mk(OP_LW, 1'b1, S_MEM_ADDR, E_ADDR),
           mk(OP_LW, 1'b0, S_MEM_READ, E_MRD)};
    foreach (seq[i]) begin
      @(negedge clk); opcode = seq[i].op; mem_ready = seq[i].rdy; #1;
      nChecks++;
      if (state !== seq[i].st || outs !== seq[i].out) begin
        nFails++;
        $display("FAIL abort_seq[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, seq[i].st, seq[i].out);
      end
    end
    @(negedge clk); rst_n = 1'b0; mem_ready = 1'b1; #1;
    nChecks++;
    if (state !== 4'(S_MEM_READ) || outs !== E_ZERO) begin
      nFails++;
      $display("FAIL abort_hold: got state=%0d outs=%b, want state=%0d outs=%b", state, outs, S_MEM_READ, E_ZERO);
    end
    @(negedge clk); #1;
    nChecks++;
    if (state !== 4'(S_FETCH) || outs !== E_ZERO) begin
      nFails++;
      $display("FAIL abort_fetch: got state=%0d outs=%b, want state=%0d outs=%b", state, outs, S_FETCH, E_ZERO);
    end
    @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk); mem_ready = 1'b1; #1;
    nChecks++;
    if (state !== 4'(S_FETCH) || outs !== E_FETCH_RD) begin
      nFails++;
      $display("FAIL abort_restart: got state=%0d outs=%b, want state=%0d outs=%b", state, outs, S_FETCH, E_FETCH_RD);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu_ops();
    test_branch_jump();
    test_illegal();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
